// File: rtl/pic24_icsp_pkg.sv
// Shared types and constants for the PIC24 ICSP programming engine.
package pic24_icsp_pkg;

  typedef enum logic [3:0] {
    StMclrLow,
    StMclrPulse,
    StKey,
    StP18,
    StP7,
    StIdle,
    StCmd4,
    StPayload,
    StRoWait8,
    StRoRead,
    StDone
  } icsp_state_e;

  localparam logic [31:0] ICSP_KEY   = 32'h4D434851;
  localparam logic [3:0]  CMD_SIX    = 4'h0;
  localparam logic [3:0]  CMD_REGOUT = 4'h1;

  // Zero bits prepended to the first SIX after reset.
  localparam int unsigned EXTRA_BITS = 5;

  // Shifter holds {instr, code} plus room for the extra leading zeros.
  localparam int unsigned SHW = 24 + 4 + EXTRA_BITS;

endpackage

// File: rtl/pic24_icsp_tick.sv
// PGC bit-cell timer: rise at cell start, fall HALFPER cycles later, last on the final cycle.
module pic24_icsp_tick #(
  parameter int unsigned HALFPER = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic rise,
  output logic fall,
  output logic last
);

  localparam logic [8:0] HALF_CNT = 9'(HALFPER);
  localparam logic [8:0] LAST_CNT = 9'(2 * HALFPER - 1);

  logic [8:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rise = en && (cnt_q == 9'd0);
  assign fall = en && (cnt_q == HALF_CNT);
  assign last = en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/pic24_icsp_engine.sv
// PIC24 ICSP master: entry sequence with key, then SIX / REGOUT commands from a one-deep slot.
module pic24_icsp_engine
  import pic24_icsp_pkg::*;
#(
  parameter int unsigned HALFPER = 2,
  parameter int unsigned P6_CYC  = 4,
  parameter int unsigned P18_CYC = 8,
  parameter int unsigned P7_CYC  = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [23:0] instr,
  input  logic        cmd,
  input  logic        valid,
  output logic        ready,
  output logic        dvalid,
  output logic [15:0] dout,
  output logic        PGCx,
  output logic        PGDx_out,
  input  logic        PGDx_in,
  output logic        PGDx_dir,
  output logic        MCLRn
);

  localparam logic [15:0] P6_LIM  = 16'(P6_CYC - 1);
  localparam logic [15:0] P18_LIM = 16'(P18_CYC - 1);
  localparam logic [15:0] P7_LIM  = 16'(P7_CYC - 1);
  localparam logic [3:0]  CMD_LEN_FIRST = 4'(4 + EXTRA_BITS);

  icsp_state_e    state_q, state_d;
  logic [15:0]    dly_q, dly_d;
  logic [5:0]     bit_cnt_q, bit_cnt_d;
  logic [SHW-1:0] shreg_q, shreg_d;
  logic           ro_q, ro_d;
  logic [3:0]     cmd_len_q, cmd_len_d;
  logic           slot_full_q, slot_full_d;
  logic           slot_cmd_q, slot_cmd_d;
  logic [23:0]    slot_instr_q, slot_instr_d;
  logic           first_q, first_d;
  logic           pgc_q, pgc_d;
  logic           pgd_q, pgd_d;
  logic           ready_q, ready_d;
  logic           dvalid_q, dvalid_d;
  logic [15:0]    dout_q, dout_d;
  logic           mclrn_q, mclrn_d;

  logic        driving, tick_en, rise, fall, last, bit_out, dly_done;
  logic [15:0] dly_lim;

  assign driving = state_q inside {StKey, StCmd4, StPayload};
  assign tick_en = driving || (state_q inside {StRoWait8, StRoRead});

  pic24_icsp_tick #(
    .HALFPER (HALFPER)
  ) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .en   (tick_en),
    .rise (rise),
    .fall (fall),
    .last (last)
  );

  always_comb begin
    bit_out = 1'b0;
    dly_lim = '0;
    unique case (state_q)
      StKey:                  bit_out = shreg_q[31];
      StCmd4, StPayload:      bit_out = shreg_q[0];
      StMclrLow, StMclrPulse: dly_lim = P6_LIM;
      StP18:                  dly_lim = P18_LIM;
      StP7:                   dly_lim = P7_LIM;
      default: ;
    endcase
  end

  assign dly_done = (dly_q == dly_lim);

  always_comb begin
    state_d      = state_q;
    dly_d        = dly_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    ro_d         = ro_q;
    cmd_len_d    = cmd_len_q;
    slot_full_d  = slot_full_q;
    slot_cmd_d   = slot_cmd_q;
    slot_instr_d = slot_instr_q;
    first_d      = first_q;
    pgc_d        = pgc_q;
    pgd_d        = pgd_q;
    ready_d      = 1'b0;
    dvalid_d     = 1'b0;
    dout_d       = dout_q;

    if (valid && !slot_full_q) begin
      slot_full_d  = 1'b1;
      slot_cmd_d   = cmd;
      slot_instr_d = instr;
    end

    if (rise) begin
      pgc_d = 1'b1;
      pgd_d = bit_out;
    end
    if (fall) begin
      pgc_d = 1'b0;
    end
    // Data is held for one cycle past the final falling edge, then parked low.
    if (!driving) begin
      pgd_d = 1'b0;
    end

    unique case (state_q)
      StMclrLow, StMclrPulse, StP18, StP7: begin
        if (dly_done) begin
          dly_d = '0;
          unique case (state_q)
            StMclrLow:   state_d = StMclrPulse;
            StMclrPulse: begin
              state_d   = StKey;
              shreg_d   = {1'b0, ICSP_KEY};
              bit_cnt_d = '0;
            end
            StP18:       state_d = StP7;
            default:     state_d = StIdle;
          endcase
        end else begin
          dly_d = dly_q + 16'd1;
        end
      end
      StKey: begin
        if (fall && (bit_cnt_q == 6'd31)) begin
          state_d = StP18;
        end else if (last) begin
          shreg_d   = {shreg_q[SHW-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      StIdle: begin
        if (slot_full_q) begin
          slot_full_d = 1'b0;
          ro_d        = slot_cmd_q;
          bit_cnt_d   = '0;
          state_d     = StCmd4;
          if (!slot_cmd_q && first_q) begin
            shreg_d   = {slot_instr_q, CMD_SIX, {EXTRA_BITS{1'b0}}};
            cmd_len_d = CMD_LEN_FIRST;
            first_d   = 1'b0;
          end else begin
            shreg_d   = {{EXTRA_BITS{1'b0}}, slot_instr_q, slot_cmd_q ? CMD_REGOUT : CMD_SIX};
            cmd_len_d = 4'd4;
          end
        end
      end
      StCmd4: begin
        if (last) begin
          shreg_d = {1'b0, shreg_q[SHW-1:1]};
          if (bit_cnt_q == 6'(cmd_len_q - 4'd1)) begin
            bit_cnt_d = '0;
            state_d   = ro_q ? StRoWait8 : StPayload;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      StPayload: begin
        if (fall && (bit_cnt_q == 6'd23)) begin
          state_d = StDone;
          ready_d = 1'b1;
        end else if (last) begin
          shreg_d   = {1'b0, shreg_q[SHW-1:1]};
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      StRoWait8: begin
        if (last) begin
          if (bit_cnt_q == 6'd7) begin
            bit_cnt_d = '0;
            state_d   = StRoRead;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      StRoRead: begin
        if (fall) begin
          shreg_d[15:0] = {PGDx_in, shreg_q[15:1]};
        end
        if (fall && (bit_cnt_q == 6'd15)) begin
          state_d  = StDone;
          ready_d  = 1'b1;
          dvalid_d = 1'b1;
          dout_d   = shreg_d[15:0];
        end else if (last) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StMclrLow;
    endcase
  end

  // Registered from the next state so MCLRn is glitch-free.
  assign mclrn_d = !(state_d inside {StMclrLow, StKey, StP18});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StMclrLow;
      dly_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      ro_q         <= 1'b0;
      cmd_len_q    <= 4'd4;
      slot_full_q  <= 1'b0;
      slot_cmd_q   <= 1'b0;
      slot_instr_q <= '0;
      first_q      <= 1'b1;
      pgc_q        <= 1'b0;
      pgd_q        <= 1'b0;
      ready_q      <= 1'b0;
      dvalid_q     <= 1'b0;
      dout_q       <= '0;
      mclrn_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      ro_q         <= ro_d;
      cmd_len_q    <= cmd_len_d;
      slot_full_q  <= slot_full_d;
      slot_cmd_q   <= slot_cmd_d;
      slot_instr_q <= slot_instr_d;
      first_q      <= first_d;
      pgc_q        <= pgc_d;
      pgd_q        <= pgd_d;
      ready_q      <= ready_d;
      dvalid_q     <= dvalid_d;
      dout_q       <= dout_d;
      mclrn_q      <= mclrn_d;
    end
  end

  assign ready    = ready_q;
  assign dvalid   = dvalid_q;
  assign dout     = dout_q;
  assign PGCx     = pgc_q;
  assign PGDx_out = pgd_q;
  assign PGDx_dir = !(state_q inside {StRoWait8, StRoRead});
  assign MCLRn    = mclrn_q;

endmodule

// File: tb/tb_pic24_icsp_engine.sv
// Directed bench for pic24_icsp_engine with a simple ICSP device model on the PGC/PGD pins.
module tb_pic24_icsp_engine;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [23:0] instr = '0;
  logic        cmd = 1'b0;
  logic        valid = 1'b0;
  logic        ready, dvalid;
  logic [15:0] dout;
  logic        PGCx, PGDx_out, PGDx_dir, MCLRn;
  logic        PGDx_in = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pic24_icsp_engine #(
    .HALFPER (2),
    .P6_CYC  (4),
    .P18_CYC (8),
    .P7_CYC  (16)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .instr    (instr),
    .cmd      (cmd),
    .valid    (valid),
    .ready    (ready),
    .dvalid   (dvalid),
    .dout     (dout),
    .PGCx     (PGCx),
    .PGDx_out (PGDx_out),
    .PGDx_in  (PGDx_in),
    .PGDx_dir (PGDx_dir),
    .MCLRn    (MCLRn)
  );

  // Device model, sampled mid-cycle: collects bits on PGC falls, drives REGOUT data on rises.
  int          cyc = 0, nfall = 0, nrise_ro = 0, ro_idx = 0;
  int          ready_cnt = 0, dvalid_cnt = 0, both_cnt = 0;
  int          last_fall_cyc = 0, mclr_rise_cyc = 0;
  logic        hi = 1'b0, hi_bit = 1'b0, mclr_prev = 1'b0;
  logic [63:0] cap = '0;
  logic [15:0] ro_word = '0;

  always @(negedge clk) begin
    cyc++;
    if (PGCx) begin
      if (!hi && !PGDx_dir) begin
        if (ro_idx >= 8) PGDx_in = ro_word[ro_idx-8];
        ro_idx++;
        nrise_ro++;
      end
      hi = 1'b1;
      hi_bit = PGDx_out;
    end else if (hi) begin
      hi = 1'b0;
      nfall++;
      cap = {cap[62:0], hi_bit};
      last_fall_cyc = cyc;
    end
    if (PGDx_dir) ro_idx = 0;
    if (MCLRn && !mclr_prev) mclr_rise_cyc = cyc;
    mclr_prev = MCLRn;
    if (ready) ready_cnt++;
    if (dvalid) dvalid_cnt++;
    if (ready && dvalid) both_cnt++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input int target, input int budget);
    int n = 0;
    while (ready_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_fall(input int target, input int budget);
    int n = 0;
    while (nfall < target && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic issue(input logic c, input logic [23:0] d);
    @(negedge clk);
    valid = 1'b1;
    cmd = c;
    instr = d;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    wait_cycles(3);
    #1;
    vectors++; if (MCLRn !== 1'b0) begin miscompares++; $display("FAIL rst_mclrn: got %b want 0", MCLRn); end
    vectors++; if (PGCx !== 1'b0) begin miscompares++; $display("FAIL rst_pgc: got %b want 0", PGCx); end
    vectors++; if (PGDx_out !== 1'b0) begin miscompares++; $display("FAIL rst_pgd: got %b want 0", PGDx_out); end
    vectors++; if (PGDx_dir !== 1'b1) begin miscompares++; $display("FAIL rst_dir: got %b want 1", PGDx_dir); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", ready); end
    vectors++; if (dvalid !== 1'b0) begin miscompares++; $display("FAIL rst_dvalid: got %b want 0", dvalid); end
    vectors++; if (dout !== 16'h0000) begin miscompares++; $display("FAIL rst_dout: got %h want 0000", dout); end
  endtask

  task automatic test_startup();
    int f0 = nfall;
    @(negedge clk);
    rstn = 1'b1;
    wait_fall(f0 + 32, 400);
    wait_cycles(12);
    vectors++; if (nfall - f0 !== 32) begin miscompares++; $display("FAIL key_bits: got %0d want 32", nfall - f0); end
    vectors++; if (cap[31:0] !== 32'h4D434851) begin miscompares++; $display("FAIL key_value: got %h want 4d434851", cap[31:0]); end
    vectors++; if (mclr_rise_cyc - last_fall_cyc !== 8) begin miscompares++; $display("FAIL p18_gap: got %0d want 8", mclr_rise_cyc - last_fall_cyc); end
    vectors++; if (MCLRn !== 1'b1) begin miscompares++; $display("FAIL mclr_released: got %b want 1", MCLRn); end
    wait_cycles(20);
  endtask

  task automatic test_first_six();
    int f0 = nfall, r0 = ready_cnt, d0 = dvalid_cnt;
    issue(1'b0, 24'h040200);
    wait_ready(r0 + 1, 400);
    wait_cycles(4);
    vectors++; if (nfall - f0 !== 33) begin miscompares++; $display("FAIL six1_bits: got %0d want 33", nfall - f0); end
    vectors++; if (cap[32:0] !== 33'h000004020) begin miscompares++; $display("FAIL six1_data: got %h want 000004020", cap[32:0]); end
    vectors++; if (ready_cnt - r0 !== 1) begin miscompares++; $display("FAIL six1_ready: got %0d want 1", ready_cnt - r0); end
    vectors++; if (dvalid_cnt - d0 !== 0) begin miscompares++; $display("FAIL six1_dvalid: got %0d want 0", dvalid_cnt - d0); end
    vectors++; if (PGCx !== 1'b0 || PGDx_out !== 1'b0) begin miscompares++; $display("FAIL six1_idle_pins: got %b%b want 00", PGCx, PGDx_out); end
  endtask

  task automatic test_six_zero();
    int f0 = nfall, r0 = ready_cnt, d0 = dvalid_cnt;
    issue(1'b0, 24'h000000);
    wait_ready(r0 + 1, 400);
    wait_cycles(4);
    vectors++; if (nfall - f0 !== 28) begin miscompares++; $display("FAIL six0_bits: got %0d want 28", nfall - f0); end
    vectors++; if (cap[27:0] !== 28'h0) begin miscompares++; $display("FAIL six0_data: got %h want 0000000", cap[27:0]); end
    vectors++; if (ready_cnt - r0 !== 1) begin miscompares++; $display("FAIL six0_ready: got %0d want 1", ready_cnt - r0); end
    vectors++; if (dvalid_cnt - d0 !== 0) begin miscompares++; $display("FAIL six0_dvalid: got %0d want 0", dvalid_cnt - d0); end
  endtask

  task automatic test_regout();
    int f0 = nfall, r0 = ready_cnt, d0 = dvalid_cnt, b0 = both_cnt, q0 = nrise_ro;
    ro_word = 16'hA5C3;
    issue(1'b1, 24'h000000);
    wait_ready(r0 + 1, 400);
    wait_cycles(4);
    vectors++; if (nfall - f0 !== 28) begin miscompares++; $display("FAIL ro_bits: got %0d want 28", nfall - f0); end
    vectors++; if (cap[27:0] !== 28'h8000000) begin miscompares++; $display("FAIL ro_code: got %h want 8000000", cap[27:0]); end
    vectors++; if (nrise_ro - q0 !== 24) begin miscompares++; $display("FAIL ro_dir_clocks: got %0d want 24", nrise_ro - q0); end
    vectors++; if (dout !== 16'hA5C3) begin miscompares++; $display("FAIL ro_dout: got %h want a5c3", dout); end
    vectors++; if (dvalid_cnt - d0 !== 1) begin miscompares++; $display("FAIL ro_dvalid: got %0d want 1", dvalid_cnt - d0); end
    vectors++; if (ready_cnt - r0 !== 1) begin miscompares++; $display("FAIL ro_ready: got %0d want 1", ready_cnt - r0); end
    vectors++; if (both_cnt - b0 !== 1) begin miscompares++; $display("FAIL ro_together: got %0d want 1", both_cnt - b0); end
    vectors++; if (PGDx_dir !== 1'b1) begin miscompares++; $display("FAIL ro_dir_after: got %b want 1", PGDx_dir); end
  endtask

  task automatic test_dout_hold();
    int f0 = nfall, r0 = ready_cnt, d0 = dvalid_cnt;
    issue(1'b0, 24'hFFFFFF);
    wait_ready(r0 + 1, 400);
    wait_cycles(4);
    vectors++; if (dout !== 16'hA5C3) begin miscompares++; $display("FAIL hold_dout: got %h want a5c3", dout); end
    vectors++; if (dvalid_cnt - d0 !== 0) begin miscompares++; $display("FAIL hold_dvalid: got %0d want 0", dvalid_cnt - d0); end
    vectors++; if (cap[27:0] !== 28'h0FFFFFF) begin miscompares++; $display("FAIL hold_data: got %h want 0ffffff", cap[27:0]); end
    vectors++; if (nfall - f0 !== 28) begin miscompares++; $display("FAIL hold_bits: got %0d want 28", nfall - f0); end
  endtask

  task automatic test_back_to_back();
    int f0 = nfall, r0 = ready_cnt, d0 = dvalid_cnt;
    ro_word = 16'h1234;
    issue(1'b0, 24'h000001);
    wait_cycles(10);
    issue(1'b1, 24'h000000);
    issue(1'b0, 24'hFFFFFF);
    wait_ready(r0 + 2, 800);
    wait_cycles(150);
    vectors++; if (ready_cnt - r0 !== 2) begin miscompares++; $display("FAIL slot_ready: got %0d want 2", ready_cnt - r0); end
    vectors++; if (dvalid_cnt - d0 !== 1) begin miscompares++; $display("FAIL slot_dvalid: got %0d want 1", dvalid_cnt - d0); end
    vectors++; if (nfall - f0 !== 56) begin miscompares++; $display("FAIL slot_bits: got %0d want 56", nfall - f0); end
    vectors++; if (dout !== 16'h1234) begin miscompares++; $display("FAIL slot_dout: got %h want 1234", dout); end
  endtask

  task automatic test_done_valid();
    int f0 = nfall, r0 = ready_cnt, n = 0;
    issue(1'b0, 24'h000002);
    while (!ready && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    valid = 1'b1;
    cmd = 1'b0;
    instr = 24'h000003;
    @(negedge clk);
    valid = 1'b0;
    wait_ready(r0 + 2, 400);
    wait_cycles(10);
    vectors++; if (ready_cnt - r0 !== 2) begin miscompares++; $display("FAIL done_ready: got %0d want 2", ready_cnt - r0); end
    vectors++; if (nfall - f0 !== 56) begin miscompares++; $display("FAIL done_bits: got %0d want 56", nfall - f0); end
    vectors++; if (cap[23:0] !== 24'hC00000) begin miscompares++; $display("FAIL done_data: got %h want c00000", cap[23:0]); end
  endtask

  task automatic test_abort();
    int f0 = nfall, r0 = ready_cnt, k0;
    issue(1'b0, 24'h0ABCDE);
    wait_fall(f0 + 14, 400);
    #2;
    rstn = 1'b0;
    #1;
    vectors++; if (MCLRn !== 1'b0) begin miscompares++; $display("FAIL abort_mclrn: got %b want 0", MCLRn); end
    vectors++; if (PGCx !== 1'b0) begin miscompares++; $display("FAIL abort_pgc: got %b want 0", PGCx); end
    vectors++; if (PGDx_dir !== 1'b1) begin miscompares++; $display("FAIL abort_dir: got %b want 1", PGDx_dir); end
    wait_cycles(3);
    k0 = nfall;
    rstn = 1'b1;
    wait_fall(k0 + 32, 400);
    wait_cycles(40);
    vectors++; if (ready_cnt - r0 !== 0) begin miscompares++; $display("FAIL abort_ready: got %0d want 0", ready_cnt - r0); end
    vectors++; if (nfall - k0 !== 32) begin miscompares++; $display("FAIL abort_key_bits: got %0d want 32", nfall - k0); end
    vectors++; if (cap[31:0] !== 32'h4D434851) begin miscompares++; $display("FAIL abort_key: got %h want 4d434851", cap[31:0]); end
  endtask

  task automatic test_held_cmd();
    int f0, r0;
    rstn = 1'b0;
    wait_cycles(2);
    f0 = nfall;
    r0 = ready_cnt;
    @(negedge clk);
    rstn = 1'b1;
    issue(1'b0, 24'h123456);
    wait_ready(r0 + 1, 800);
    wait_cycles(150);
    vectors++; if (ready_cnt - r0 !== 1) begin miscompares++; $display("FAIL held_ready: got %0d want 1", ready_cnt - r0); end
    vectors++; if (nfall - f0 !== 65) begin miscompares++; $display("FAIL held_bits: got %0d want 65", nfall - f0); end
    vectors++; if (cap[32:24] !== 9'h000) begin miscompares++; $display("FAIL held_prefix: got %h want 000", cap[32:24]); end
    vectors++; if (cap[23:0] !== 24'h6A2C48) begin miscompares++; $display("FAIL held_data: got %h want 6a2c48", cap[23:0]); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_first_six();
    test_six_zero();
    test_regout();
    test_dout_hold();
    test_back_to_back();
    test_done_valid();
    test_abort();
    test_held_cmd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
